// File: rtl/br_regfile.sv
// Two-read / one-write register bank: combinational read ports, one clocked
// write port, optional hard-wired zero register at address 0.
module br_regfile #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter bit ZERO_R0 = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] RR1,
  input  logic [ADDR_W-1:0] RR2,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              RegWrite,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Storage keeps the name BR so benches can reach it hierarchically.
  logic [DATA_W-1:0] BR   [DEPTH];
  logic [DATA_W-1:0] br_d [DEPTH];
  logic              wr_en;

  // Writes to register 0 are dropped when it is hard-wired to zero.
  assign wr_en = RegWrite && !(ZERO_R0 && (WriteReg == '0));

  always_comb begin
    // NOTE: copy the current contents first so every path assigns br_d and
    // no latch is inferred for entries that are not being written.
    br_d = BR;
    if (wr_en) begin
      br_d[WriteReg] = WriteData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this bank is built from flops, not an SRAM macro, so every entry
      // can and must be cleared by the asynchronous reset.
      for (int i = 0; i < DEPTH; i++) begin
        BR[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking so all entries update together at the edge.
      BR <= br_d;
    end
  end

  // No bypass: a write becomes visible only after its clock edge.
  always_comb begin
    RD1 = BR[RR1];
    RD2 = BR[RR2];
    if (ZERO_R0 && (RR1 == '0)) RD1 = '0;
    if (ZERO_R0 && (RR2 == '0)) RD2 = '0;
  end

endmodule

// File: tb/tb_br_regfile.sv
// Scoreboard bench for br_regfile: one instance with an ordinary register 0
// and one with a hard-wired zero register, both driven by the same stimulus.
module tb_br_regfile;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic [AW-1:0] RR1       = '0;
  logic [AW-1:0] RR2       = '0;
  logic [AW-1:0] WriteReg  = '0;
  logic [DW-1:0] WriteData = '0;
  logic          RegWrite  = 1'b0;
  logic [DW-1:0] rd1_a, rd2_a, rd1_z, rd2_z;

  always #5 clk = ~clk;

  br_regfile #(.DATA_W(DW), .ADDR_W(AW), .ZERO_R0(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .RR1(RR1), .RR2(RR2), .WriteReg(WriteReg),
    .WriteData(WriteData), .RegWrite(RegWrite), .RD1(rd1_a), .RD2(rd2_a)
  );

  br_regfile #(.DATA_W(DW), .ADDR_W(AW), .ZERO_R0(1'b1)) dut_z (
    .clk(clk), .rst_n(rst_n), .RR1(RR1), .RR2(RR2), .WriteReg(WriteReg),
    .WriteData(WriteData), .RegWrite(RegWrite), .RD1(rd1_z), .RD2(rd2_z)
  );

  typedef struct {
    string         name;
    logic [DW-1:0] e1;
    logic [DW-1:0] e2;
    logic [DW-1:0] z1;
    logic [DW-1:0] z2;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference contents: plain arrays of what each register should hold.
  logic [DW-1:0] m_a [DEPTH];
  logic [DW-1:0] m_z [DEPTH];
  bit            pend_we   = 1'b0;
  bit            pend_rst  = 1'b0;
  int            pend_addr = 0;
  logic [DW-1:0] pend_data = '0;
  logic [DW-1:0] v11, v17;

  task automatic check(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_z(input int a);
    return (a == 0) ? '0 : m_z[a];
  endfunction

  // One clock cycle of stimulus: commit the write launched last cycle into the
  // model, drive new inputs, apply an asynchronous reset to the model at once,
  // and queue what both read ports must show before the next edge.
  task automatic step(input string name, input bit rst, input bit we,
                      input int waddr, input logic [DW-1:0] wdata,
                      input int r1, input int r2, input bit chk);
    @(posedge clk);
    #1;
    if (pend_we && pend_rst) begin
      m_a[pend_addr] = pend_data;
      if (pend_addr != 0) m_z[pend_addr] = pend_data;
    end
    rst_n     = rst;
    RegWrite  = we;
    WriteReg  = AW'(waddr);
    WriteData = wdata;
    RR1       = AW'(r1);
    RR2       = AW'(r2);
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_a[i] = '0;
        m_z[i] = '0;
      end
    end
    pend_we   = we;
    pend_rst  = rst;
    pend_addr = waddr;
    pend_data = wdata;
    if (chk) sb_q.push_back('{name, m_a[r1], m_a[r2], ref_z(r1), ref_z(r2)});
  endtask

  // Monitor: reads are combinational, so outputs are valid at every falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check({e.name, "/rd1"}, rd1_a, e.e1);
        check({e.name, "/rd2"}, rd2_a, e.e2);
        check({e.name, "/rd1_z"}, rd1_z, e.z1);
        check({e.name, "/rd2_z"}, rd2_z, e.z2);
      end
    end
  end

  initial begin
    v11 = $urandom;
    v17 = $urandom;

    step("rst_low",     1'b0, 1'b0, 0, '0, 31, 1, 1'b1);
    step("rst_release", 1'b1, 1'b0, 0, '0, 31, 1, 1'b1);

    step("pre31", 1'b1, 1'b1, 31, 32'h0000_0005, 31, 1, 1'b0);
    step("pre1",  1'b1, 1'b1, 1,  32'h0000_0001, 31, 1, 1'b0);
    step("pre11", 1'b1, 1'b1, 11, v11,           31, 1, 1'b0);
    step("pre17", 1'b1, 1'b1, 17, v17,           31, 1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step("hold", 1'b1, 1'b0, 0, '0, 31, 1, 1'b1);
    end

    step("rdw_before", 1'b1, 1'b1, 31, 32'hFFFF_FFFF, 31, 1, 1'b1);
    step("rdw_after",  1'b1, 1'b0, 0,  '0,            31, 1, 1'b1);

    step("ovr_wr",    1'b1, 1'b1, 31, 32'd23, 31, 1,  1'b1);
    step("ovr_after", 1'b1, 1'b0, 0,  '0,     31, 1,  1'b1);
    step("ovr_keep",  1'b1, 1'b0, 0,  '0,     11, 17, 1'b1);

    step("w17_before", 1'b1, 1'b1, 17, 32'd47, 31, 17, 1'b1);
    step("w17_after",  1'b1, 1'b0, 0,  '0,     31, 17, 1'b1);
    step("rst_vs_wr",  1'b0, 1'b1, 17, 32'd99, 17, 31, 1'b1);
    step("rst_won",    1'b1, 1'b0, 0,  '0,     17, 31, 1'b1);

    step("same_wr",   1'b1, 1'b1, 9, 32'hA5A5_5A5A, 9, 9, 1'b1);
    step("same_rd",   1'b1, 1'b0, 0, '0,            9, 9, 1'b1);

    for (int i = 0; i < DEPTH; i++) begin
      step("sweep_wr", 1'b1, 1'b1, i, DW'(i + 100), i, DEPTH - 1 - i, 1'b1);
    end
    for (int i = 0; i < DEPTH; i++) begin
      step("sweep_rd", 1'b1, 1'b0, 0, '0, i, DEPTH - 1 - i, 1'b1);
    end

    for (int n = 0; n < 400; n++) begin
      step("rand", ($urandom_range(0, 39) != 0), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, DEPTH - 1)), $urandom,
           int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH - 1)),
           1'b1);
    end
    step("final", 1'b1, 1'b0, 0, '0, 0, 31, 1'b1);

    for (int k = 0; k < 10 && sb_q.size() > 0; k++) begin
      @(negedge clk);
      #1;
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
